// File: rtl/layer_sequencer.sv
// layer_sequencer: launches NUM_STAGES active-low stage-run strobes at fixed cycle offsets after start.
//   clk, reset       : clock, synchronous active-high reset
//   start, abort     : launch request (IDLE/DONE only), return-to-IDLE (wins over start)
//   auto_restart     : sampled at completion, 1 reruns the sequence immediately
//   stage_run_n      : per-stage run strobe, low once launched
//   stage_idx        : number of stages launched in the current sequence
//   busy, done_flag  : RUN indicator, DONE indicator
//   done_pulse       : one-cycle pulse per completion
//   iter_cnt         : completed sequences since reset, wrapping
//   debug_cc         : current cycle counter
module layer_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CC_W = 8,
    parameter logic [NUM_STAGES*CC_W-1:0] STAGE_CC = 40'h0B_060B_080F,
    parameter int OFFSET = 2,
    parameter int CNT_W = 7,
    parameter int ITER_W = 8,
    localparam int IDX_W = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  auto_restart,
    output logic [NUM_STAGES-1:0] stage_run_n,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  busy,
    output logic                  done_flag,
    output logic                  done_pulse,
    output logic [ITER_W-1:0]     iter_cnt,
    output logic [CNT_W-1:0]      debug_cc
);
    // Launch cycle of stage i; i == NUM_STAGES gives the completion cycle.
    function automatic int launch_at(input int i);
        int s;
        s = OFFSET;
        for (int j = 0; j < i; j++) s += int'(STAGE_CC[j*CC_W +: CC_W]);
        return s;
    endfunction

    localparam int TOTAL = launch_at(NUM_STAGES);

    if (NUM_STAGES < 1 || TOTAL > 2**CNT_W - 1) begin : g_bad_params
        $error("layer_sequencer: NUM_STAGES < 1 or OFFSET + sum(STAGE_CC) exceeds CNT_W counter");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cc_q, cc_d;
    logic [NUM_STAGES-1:0] run_n_q, run_n_d, hit;
    logic [IDX_W-1:0]      idx_q, idx_d, n_hit;
    logic                  flag_q, flag_d, pulse_q, pulse_d;
    logic [ITER_W-1:0]     iter_q, iter_d;

    always_comb begin
        hit = '0;
        n_hit = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hit[i] = (cc_q == CNT_W'(launch_at(i)));
            n_hit = n_hit + IDX_W'(hit[i]);
        end
        state_d = state_q;
        cc_d = cc_q;
        run_n_d = run_n_q;
        idx_d = idx_q;
        flag_d = flag_q;
        pulse_d = 1'b0;
        iter_d = iter_q;
        if (abort) begin
            state_d = IDLE;
            cc_d = '0;
            run_n_d = '1;
            idx_d = '0;
            flag_d = 1'b0;
        end else if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                cc_d = '0;
                run_n_d = '1;
                idx_d = '0;
                flag_d = 1'b0;
            end
        end else begin
            cc_d = cc_q + CNT_W'(1);
            run_n_d = run_n_q & ~hit;
            idx_d = idx_q + n_hit;
            if (cc_q == CNT_W'(TOTAL)) begin
                pulse_d = 1'b1;
                iter_d = iter_q + ITER_W'(1);
                if (auto_restart) begin
                    cc_d = '0;
                    run_n_d = '1;
                    idx_d = '0;
                end else begin
                    // Counter freezes at TOTAL; any stage launching at TOTAL still clears above.
                    state_d = DONE;
                    flag_d = 1'b1;
                    cc_d = cc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cc_q <= '0;
            run_n_q <= '1;
            idx_q <= '0;
            flag_q <= 1'b0;
            pulse_q <= 1'b0;
            iter_q <= '0;
        end else begin
            state_q <= state_d;
            cc_q <= cc_d;
            run_n_q <= run_n_d;
            idx_q <= idx_d;
            flag_q <= flag_d;
            pulse_q <= pulse_d;
            iter_q <= iter_d;
        end
    end

    assign stage_run_n = run_n_q;
    assign stage_idx = idx_q;
    assign busy = (state_q == RUN);
    assign done_flag = flag_q;
    assign done_pulse = pulse_q;
    assign iter_cnt = iter_q;
    assign debug_cc = cc_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of strobe timing, completion, restart, abort and reset.
module tb_layer_sequencer;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, auto_restart = 1'b0;
    logic [4:0] s0, s1;
    logic [2:0] idx0, idx1;
    logic [7:0] iter0, iter1;
    logic [6:0] cc0, cc1;
    logic busy0, flag0, pulse0, busy1, flag1, pulse1;
    logic [1:0] s2, idx2, iter2;
    logic [2:0] cc2;
    logic busy2, flag2, pulse2;
    int checks = 0, errors = 0;
    int f0[5], f1[5], f2[2];
    int pq0[$], pq1[$], pq2[$];
    int refall0, idx1_23, idx1_24, iter2_19, iter2_20;
    logic flag_seen0, prev0, flag_e0, busy_e0, busy_e1;
    logic [4:0] s0_e0, s0_54;
    int exp0[5] = '{3, 18, 26, 37, 43};
    int exp1[5] = '{1, 16, 24, 24, 30};
    int exp2[2] = '{2, 5};

    always #5 clk = ~clk;

    layer_sequencer u0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .auto_restart(auto_restart),
        .stage_run_n(s0), .stage_idx(idx0), .busy(busy0), .done_flag(flag0),
        .done_pulse(pulse0), .iter_cnt(iter0), .debug_cc(cc0)
    );
    layer_sequencer #(.STAGE_CC(40'h0B_06_00_08_0F), .OFFSET(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .auto_restart(auto_restart),
        .stage_run_n(s1), .stage_idx(idx1), .busy(busy1), .done_flag(flag1),
        .done_pulse(pulse1), .iter_cnt(iter1), .debug_cc(cc1)
    );
    layer_sequencer #(.NUM_STAGES(2), .CC_W(4), .STAGE_CC(8'h03), .OFFSET(1), .CNT_W(3), .ITER_W(2)) u2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .auto_restart(auto_restart),
        .stage_run_n(s2), .stage_idx(idx2), .busy(busy2), .done_flag(flag2),
        .done_pulse(pulse2), .iter_cnt(iter2), .debug_cc(cc2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Start sampled at edge 0, then record per-edge events up to edge n; start re-pulsed at edge inj.
    task automatic run_seq(input int n, input int inj);
        for (int i = 0; i < 5; i++) begin
            f0[i] = -1;
            f1[i] = -1;
        end
        f2[0] = -1;
        f2[1] = -1;
        pq0.delete();
        pq1.delete();
        pq2.delete();
        flag_seen0 = 1'b0;
        refall0 = -1;
        start = 1'b1;
        tick;
        start = 1'b0;
        s0_e0 = s0;
        flag_e0 = flag0;
        busy_e0 = busy0;
        prev0 = s0[0];
        for (int e = 1; e <= n; e++) begin
            start = (e == inj);
            tick;
            for (int i = 0; i < 5; i++) begin
                if (f0[i] < 0 && !s0[i]) f0[i] = e;
                if (f1[i] < 0 && !s1[i]) f1[i] = e;
            end
            for (int i = 0; i < 2; i++) if (f2[i] < 0 && !s2[i]) f2[i] = e;
            if (pulse0) pq0.push_back(e);
            if (pulse1) pq1.push_back(e);
            if (pulse2) pq2.push_back(e);
            if (flag0) flag_seen0 = 1'b1;
            if (pq0.size() > 0 && prev0 && !s0[0] && refall0 < 0) refall0 = e;
            prev0 = s0[0];
            if (e == 1) busy_e1 = busy0;
            if (e == 23) idx1_23 = idx1;
            if (e == 24) idx1_24 = idx1;
            if (e == 19) iter2_19 = iter2;
            if (e == 20) iter2_20 = iter2;
            if (e == 54) s0_54 = s0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (s0 !== 5'h1F) begin errors++; $display("FAIL reset_run_n got %h exp 1f", s0); end
        checks++; if (idx0 !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
        checks++; if (flag0 !== 1'b0) begin errors++; $display("FAIL reset_done_flag got %b exp 0", flag0); end
        checks++; if (pulse0 !== 1'b0) begin errors++; $display("FAIL reset_done_pulse got %b exp 0", pulse0); end
        checks++; if (iter0 !== 8'd0) begin errors++; $display("FAIL reset_iter got %0d exp 0", iter0); end
        checks++; if (cc0 !== 7'd0) begin errors++; $display("FAIL reset_cc got %0d exp 0", cc0); end
    endtask

    task automatic test_timing;
        do_reset;
        run_seq(60, -1);
        checks++; if (busy_e1 !== 1'b1) begin errors++; $display("FAIL busy_in_run got %b exp 1", busy_e1); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (f0[i] != exp0[i]) begin errors++; $display("FAIL u0_fall[%0d] got %0d exp %0d", i, f0[i], exp0[i]); end
            checks++; if (f1[i] != exp1[i]) begin errors++; $display("FAIL u1_fall[%0d] got %0d exp %0d", i, f1[i], exp1[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (f2[i] != exp2[i]) begin errors++; $display("FAIL u2_fall[%0d] got %0d exp %0d", i, f2[i], exp2[i]); end
        end
        checks++; if (pq0.size() != 1 || pq0[0] != 54) begin errors++; $display("FAIL u0_pulse got n=%0d first=%0d exp n=1 first=54", pq0.size(), pq0[0]); end
        checks++; if (pq1.size() != 1 || pq1[0] != 41) begin errors++; $display("FAIL u1_pulse got n=%0d first=%0d exp n=1 first=41", pq1.size(), pq1[0]); end
        checks++; if (pq2.size() != 1 || pq2[0] != 5) begin errors++; $display("FAIL u2_pulse got n=%0d first=%0d exp n=1 first=5", pq2.size(), pq2[0]); end
        checks++; if (idx1_23 != 2 || idx1_24 != 4) begin errors++; $display("FAIL u1_idx_jump got %0d->%0d exp 2->4", idx1_23, idx1_24); end
        checks++; if (flag0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL u0_done_state got flag=%b busy=%b exp flag=1 busy=0", flag0, busy0); end
        checks++; if (s0 !== 5'h00 || idx0 !== 3'd5) begin errors++; $display("FAIL u0_done_strobes got %h idx=%0d exp 00 idx=5", s0, idx0); end
        checks++; if (iter0 !== 8'd1) begin errors++; $display("FAIL u0_iter got %0d exp 1", iter0); end
        checks++; if (cc0 !== 7'd53) begin errors++; $display("FAIL u0_cc_hold got %0d exp 53", cc0); end
        checks++; if (cc1 !== 7'd40 || flag1 !== 1'b1 || busy1 !== 1'b0 || iter1 !== 8'd1) begin errors++; $display("FAIL u1_done got cc=%0d flag=%b busy=%b iter=%0d exp 40 1 0 1", cc1, flag1, busy1, iter1); end
        checks++; if (cc2 !== 3'd4 || flag2 !== 1'b1 || busy2 !== 1'b0 || idx2 !== 2'd2) begin errors++; $display("FAIL u2_done got cc=%0d flag=%b busy=%b idx=%0d exp 4 1 0 2", cc2, flag2, busy2, idx2); end
    endtask

    task automatic test_back_to_back;
        run_seq(60, 10);
        checks++; if (s0_e0 !== 5'h1F || flag_e0 !== 1'b0 || busy_e0 !== 1'b1) begin errors++; $display("FAIL restart_entry got run_n=%h flag=%b busy=%b exp 1f 0 1", s0_e0, flag_e0, busy_e0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (f0[i] != exp0[i]) begin errors++; $display("FAIL restart_u0_fall[%0d] got %0d exp %0d", i, f0[i], exp0[i]); end
            checks++; if (f1[i] != exp1[i]) begin errors++; $display("FAIL restart_u1_fall[%0d] got %0d exp %0d", i, f1[i], exp1[i]); end
        end
        checks++; if (pq0.size() != 1 || pq0[0] != 54) begin errors++; $display("FAIL restart_u0_pulse got n=%0d first=%0d exp n=1 first=54", pq0.size(), pq0[0]); end
        checks++; if (iter0 !== 8'd2) begin errors++; $display("FAIL restart_iter got %0d exp 2", iter0); end
    endtask

    task automatic test_auto_restart;
        do_reset;
        auto_restart = 1'b1;
        run_seq(165, -1);
        auto_restart = 1'b0;
        checks++; if (pq0.size() != 3 || pq0[0] != 54 || pq0[1] != 108 || pq0[2] != 162) begin errors++; $display("FAIL auto_pulses got n=%0d %0d %0d %0d exp 54 108 162", pq0.size(), pq0[0], pq0[1], pq0[2]); end
        checks++; if (flag_seen0 !== 1'b0) begin errors++; $display("FAIL auto_done_flag got %b exp 0", flag_seen0); end
        checks++; if (s0_54 !== 5'h1F) begin errors++; $display("FAIL auto_rearm got %h exp 1f", s0_54); end
        checks++; if (refall0 != 57) begin errors++; $display("FAIL auto_refall got %0d exp 57", refall0); end
        checks++; if (iter0 !== 8'd3) begin errors++; $display("FAIL auto_iter got %0d exp 3", iter0); end
        checks++; if (iter2_19 != 3 || iter2_20 != 0) begin errors++; $display("FAIL iter_wrap got %0d->%0d exp 3->0", iter2_19, iter2_20); end
    endtask

    task automatic test_abort;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        checks++; if (s0 !== 5'b11100) begin errors++; $display("FAIL pre_abort_run_n got %b exp 11100", s0); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++; if (s0 !== 5'h1F || busy0 !== 1'b0 || idx0 !== 3'd0) begin errors++; $display("FAIL abort_state got run_n=%h busy=%b idx=%0d exp 1f 0 0", s0, busy0, idx0); end
        checks++; if (pulse0 !== 1'b0 || iter0 !== 8'd0 || cc0 !== 7'd0 || flag0 !== 1'b0) begin errors++; $display("FAIL abort_counts got pulse=%b iter=%0d cc=%0d flag=%b exp 0 0 0 0", pulse0, iter0, cc0, flag0); end
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy0 !== 1'b0 || s0 !== 5'h1F) begin errors++; $display("FAIL abort_beats_start got busy=%b run_n=%h exp 0 1f", busy0, s0); end
        tick;
        checks++; if (busy0 !== 1'b0 || cc0 !== 7'd0) begin errors++; $display("FAIL abort_stays_idle got busy=%b cc=%0d exp 0 0", busy0, cc0); end
    endtask

    task automatic test_reset_mid_run;
        do_reset;
        run_seq(56, -1);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (30) tick;
        checks++; if (cc0 !== 7'd30 || iter0 !== 8'd1) begin errors++; $display("FAIL pre_reset got cc=%0d iter=%0d exp 30 1", cc0, iter0); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (s0 !== 5'h1F || idx0 !== 3'd0 || busy0 !== 1'b0 || flag0 !== 1'b0) begin errors++; $display("FAIL midrun_reset got run_n=%h idx=%0d busy=%b flag=%b exp 1f 0 0 0", s0, idx0, busy0, flag0); end
        checks++; if (pulse0 !== 1'b0 || iter0 !== 8'd0 || cc0 !== 7'd0) begin errors++; $display("FAIL midrun_reset_cnt got pulse=%b iter=%0d cc=%0d exp 0 0 0", pulse0, iter0, cc0); end
        run_seq(56, -1);
        checks++; if (f0[0] != 3 || f0[4] != 43) begin errors++; $display("FAIL post_reset_fall got %0d %0d exp 3 43", f0[0], f0[4]); end
        checks++; if (pq0.size() != 1 || pq0[0] != 54 || iter0 !== 8'd1) begin errors++; $display("FAIL post_reset_done got n=%0d first=%0d iter=%0d exp 1 54 1", pq0.size(), pq0[0], iter0); end
    endtask

    initial begin
        test_reset;
        test_timing;
        test_back_to_back;
        test_auto_restart;
        test_abort;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Parametrised successor of the fixed encoder start-timing controller in the inference pipeline.
- Drives NUM_STAGES active-low stage-run strobes (enc/softplus/lambda/sigmoid chain) at programmable cycle offsets.
- Adds an explicit start/abort handshake, a done pulse, optional auto-restart for back-to-back inferences, and an iteration counter.
- Sits between the top-level datapath controller and the per-layer compute blocks.

Parameters:
- NUM_STAGES, 5, number of stage strobes (≥1).
- CC_W, 8, width of each per-stage duration field.
- STAGE_CC, 40'h0B_060B_080F, flat NUM_STAGES*CC_W vector, stage 0 in LSBs. Field i = cycles from launch of stage i to launch of stage i+1; for the last stage, to completion. Zero is legal.
- OFFSET, 2, cycles from run entry to launch of stage 0.
- CNT_W, 7, cycle-counter width. TOTAL = OFFSET + sum(STAGE_CC) must be ≤ 2^CNT_W−1, otherwise elaboration error.
- ITER_W, 8, iteration-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  level; sampled in IDLE or DONE to launch a sequence.
- abort  in  1  returns the block to IDLE; priority over start.
- auto_restart  in  1  sampled at completion; 1 = rerun immediately.
- stage_run_n  out  NUM_STAGES  active-low run strobe per stage; held low once launched.
- stage_idx  out  clog2(NUM_STAGES+1)  number of stages launched so far.
- busy  out  1  high in RUN.
- done_flag  out  1  level, high in DONE.
- done_pulse  out  1  one-cycle pulse at each completion, including auto-restarts.
- iter_cnt  out  ITER_W  completed sequences since reset, wraps modulo 2^ITER_W.
- debug_cc  out  CNT_W  current cycle counter.

Behaviour:
- Reset is synchronous, sampled on the clk rising edge. Reset values:
  - state = IDLE.
  - stage_run_n = all 1.
  - stage_idx = 0, busy = 0, done_flag = 0, done_pulse = 0, iter_cnt = 0, debug_cc = 0.
- Reset mid-RUN behaves identically to reset from IDLE.
- Launch times: LAUNCH[i] = OFFSET + sum(STAGE_CC[0..i-1]). These are precomputed constants.
- States:
  - IDLE: outputs at reset values except iter_cnt. start=1 → RUN next cycle with cc = 0, busy = 1.
  - RUN: cc increments by 1 every cycle.
    - On every edge where cc == LAUNCH[i], stage_run_n[i] is cleared to 0.
    - Stages with equal LAUNCH values (zero-length fields) clear on the same edge, and stage_idx advances by the count launched on that edge.
    - When cc == TOTAL, completion occurs on that edge:
      - done_pulse = 1 for one cycle.
      - iter_cnt increments.
      - If auto_restart = 0: → DONE with done_flag = 1, busy = 0. stage_run_n stays all 0 and cc holds at TOTAL.
      - If auto_restart = 1: stay in RUN with cc = 0, stage_run_n = all 1, stage_idx = 0, done_flag stays 0.
  - DONE: all outputs hold. start=1 → RUN with cc = 0, stage_run_n = all 1, stage_idx = 0, done_flag = 0.
- Timing: if start is sampled at edge k, stage_run_n[i] falls at edge k+1+LAUNCH[i], and done_pulse/done_flag rise at edge k+1+TOTAL.
- abort = 1 in any state → IDLE next edge. stage_run_n = all 1, done_flag = 0, cc = 0. iter_cnt is unchanged and no done_pulse is issued. Simultaneous abort and start → abort wins.
- A stage whose LAUNCH equals TOTAL clears stage_run_n on the same edge completion occurs.
- start asserted while in RUN is ignored.
- iter_cnt wraps from 2^ITER_W−1 to 0.

Test Plan:
- Defaults; reset, start=1 for one cycle at edge 0 → stage_run_n[0..4] fall at edges 3, 18, 26, 37, 43. done_flag and done_pulse rise at edge 54. iter_cnt = 1. debug_cc = 53 held.
- After DONE, assert start again → all strobes return to 1 on the next edge and the timing above repeats exactly. iter_cnt = 2.
- auto_restart=1, single start → done_pulse at edges 54, 108, 162. done_flag never rises. stage_run_n[0] refalls at edge 57.
- abort at edge 20 (stages 0–1 launched) → edge 21: IDLE, stage_run_n = 5'b11111, busy = 0, no done_pulse, iter_cnt = 0. abort and start together at edge 25 → remains IDLE.
- STAGE_CC = {11, 6, 0, 8, 15}, OFFSET = 0 → stages 2 and 3 fall on the same edge (LAUNCH = 23). stage_idx jumps from 2 to 4. Completion at TOTAL = 40.
- Reset asserted mid-RUN at cc = 30 → next edge all outputs at reset values, iter_cnt = 0. A later start runs normally.
